// File: rtl/fetch_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : fetch_unit                                                    |
// | Purpose  : Instruction fetch stage. Owns the 12-bit PC, reads one byte   |
// |            per memory access, assembles 1- or 2-byte instructions and    |
// |            offers them to decode over a valid/ready handshake. Accepts   |
// |            branch/call and return redirects from execute.                |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module fetch_unit #(
  parameter logic [11:0] RESET_PC = 12'h000
) (
  input  logic        clk,
  input  logic        reset_,
  output logic [11:0] i_mem_addr,
  output logic        i_mem_rd,
  input  logic [7:0]  i_mem_data_in,
  output logic [7:0]  instr_byte0,
  output logic [7:0]  instr_byte1,
  input  logic        need_byte2,
  output logic        instr_vld,
  input  logic        decode_ready,
  output logic [11:0] next_addr,
  input  logic        pc_branch,
  input  logic [11:0] dst_addr,
  input  logic        ret_addr_en,
  input  logic [11:0] ret_addr
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH0 = 3'd1,
    ST_WAIT0  = 3'd2,
    ST_FETCH1 = 3'd3,
    ST_WAIT1  = 3'd4,
    ST_ISSUE  = 3'd5
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [11:0] r_pc;
  logic [11:0] w_pc_nxt;
  logic [11:0] w_pc_inc;
  logic [7:0]  r_byte0;
  logic [7:0]  r_byte1;
  logic        r_mem_rd;
  logic        r_instr_vld;
  logic        w_redirect;
  logic [11:0] w_redirect_pc;
  logic        w_in_wait0;

  // Redirects are ignored only in IDLE; a return outranks a branch/call.
  assign w_redirect    = (r_state != ST_IDLE) && (pc_branch || ret_addr_en);
  assign w_redirect_pc = ret_addr_en ? ret_addr : dst_addr;

  // 12-bit modulo increment; wraps 12'hFFF to 12'h000 naturally.
  assign w_pc_inc   = r_pc + 12'd1;
  assign w_in_wait0 = (r_state == ST_WAIT0);

  // Next-state and next-PC selection; a redirect overrides the normal sequence.
  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    case (r_state)
      ST_IDLE: begin
        w_state_nxt = ST_FETCH0;
      end
      ST_FETCH0: begin
        w_state_nxt = ST_WAIT0;
      end
      ST_WAIT0: begin
        w_pc_nxt    = w_pc_inc;
        w_state_nxt = need_byte2 ? ST_FETCH1 : ST_ISSUE;
      end
      ST_FETCH1: begin
        w_state_nxt = ST_WAIT1;
      end
      ST_WAIT1: begin
        w_pc_nxt    = w_pc_inc;
        w_state_nxt = ST_ISSUE;
      end
      ST_ISSUE: begin
        if (decode_ready) begin
          w_state_nxt = ST_FETCH0;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
    if (w_redirect) begin
      w_state_nxt = ST_FETCH0;
      w_pc_nxt    = w_redirect_pc;
    end
  end

  // State, PC, instruction bytes and registered strobes.
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      r_state     <= ST_IDLE;
      r_pc        <= RESET_PC;
      r_byte0     <= 8'h00;
      r_byte1     <= 8'h00;
      r_mem_rd    <= 1'b0;
      r_instr_vld <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_pc        <= w_pc_nxt;
      // Strobes follow the state being entered so they line up with it.
      r_mem_rd    <= (w_state_nxt == ST_FETCH0) || (w_state_nxt == ST_FETCH1);
      r_instr_vld <= (w_state_nxt == ST_ISSUE);
      // Read data arriving during a redirect belongs to a discarded fetch.
      if (w_in_wait0 && !w_redirect) begin
        r_byte0 <= i_mem_data_in;
        if (!need_byte2) begin
          r_byte1 <= 8'h00;
        end
      end
      if ((r_state == ST_WAIT1) && !w_redirect) begin
        r_byte1 <= i_mem_data_in;
      end
    end
  end

  // Byte0 is forwarded straight from memory in WAIT0 so decode can derive
  // need_byte2 in the same cycle the opcode arrives.
  assign instr_byte0 = w_in_wait0 ? i_mem_data_in : r_byte0;
  assign instr_byte1 = r_byte1;
  assign i_mem_addr  = r_pc;
  assign next_addr   = r_pc;
  assign i_mem_rd    = r_mem_rd;
  assign instr_vld   = r_instr_vld;

endmodule
`default_nettype wire
